// File: rtl/axi_addr_router_n_if.sv
// Master-side AXI address channel (AR or AW) bundle for axi_addr_router_n.
// The master modport drives the request; the slave modport (the router) returns ready.
interface axi_addr_router_n_if;
  logic [31:0] addr;
  logic [7:0]  len;
  logic [2:0]  size;
  logic [1:0]  burst;
  logic        valid;
  logic        ready;

  modport master (output addr, output len, output size, output burst, output valid,
                  input  ready);
  modport slave  (input  addr, input  len, input  size, input  burst, input  valid,
                  output ready);
endinterface

// File: rtl/axi_addr_router_n.sv
// axi_addr_router_n: one AXI address channel fanned out to NUM_SLAVES slaves.
// Each accepted request records its target in an in-order select FIFO that the
// data/response mux pops to steer returning beats. Requests to a different
// target than the outstanding ones are held, so ordering holds without IDs.
// Optional feature macro: ROUTER_DECERR_EN -- unmapped requests are absorbed by
// an internal error sink and queued as decode-error entries instead of being
// routed to DEFAULT_SLAVE.
module axi_addr_router_n #(
  parameter int                          NUM_SLAVES      = 5,
  parameter int                          SEL_W           = 3,
  parameter logic [NUM_SLAVES*16-1:0]    SLAVE_BASE      = {16'h0004, 16'h0003, 16'h0002, 16'h0001, 16'h0000},
  parameter logic [NUM_SLAVES*16-1:0]    SLAVE_MASK      = {5{16'hFFFF}},
  parameter int                          DEFAULT_SLAVE   = 0,
  parameter int                          MAX_OUTSTANDING = 4,
  localparam int                         PTR_W           = $clog2(MAX_OUTSTANDING),
  localparam int                         CNT_W           = $clog2(MAX_OUTSTANDING) + 1
) (
  input  logic                      clk,
  input  logic                      reset,
  axi_addr_router_n_if.slave        m_if,
  output logic [NUM_SLAVES*32-1:0]  o_s_addr,
  output logic [NUM_SLAVES*8-1:0]   o_s_len,
  output logic [NUM_SLAVES*3-1:0]   o_s_size,
  output logic [NUM_SLAVES*2-1:0]   o_s_burst,
  output logic [NUM_SLAVES-1:0]     o_s_valid,
  input  logic [NUM_SLAVES-1:0]     i_s_ready,
  output logic [SEL_W-1:0]          o_sel_q,
  output logic                      o_sel_err,
  output logic                      o_sel_valid,
  input  logic                      i_rsp_done,
  output logic [CNT_W-1:0]          o_outstanding
);

  logic [SEL_W-1:0] w_tgt;
  logic             w_miss;
  logic             w_pop;
  logic             w_full;
  logic             w_busy;
  logic             w_stall;
  logic             w_ready;
  logic             w_push;
  logic [SEL_W-1:0] w_push_sel;

  logic [SEL_W-1:0] r_mem_sel [MAX_OUTSTANDING];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [CNT_W-1:0] r_count;
  logic [SEL_W-1:0] r_last_tgt;
  logic             r_last_err;

  // Payload is broadcast unchanged to every slave; only valid is steered.
  assign o_s_addr  = {NUM_SLAVES{m_if.addr}};
  assign o_s_len   = {NUM_SLAVES{m_if.len}};
  assign o_s_size  = {NUM_SLAVES{m_if.size}};
  assign o_s_burst = {NUM_SLAVES{m_if.burst}};

  // Address decode: scan from the top so the lowest matching index wins.
  always_comb begin
    w_miss = 1'b1;
    w_tgt  = SEL_W'(DEFAULT_SLAVE);
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if ((m_if.addr[31:16] & SLAVE_MASK[16*i +: 16]) ==
          (SLAVE_BASE[16*i +: 16] & SLAVE_MASK[16*i +: 16])) begin
        w_miss = 1'b0;
        w_tgt  = SEL_W'(i);
      end else begin
        w_miss = w_miss;
        w_tgt  = w_tgt;
      end
    end
  end

  // A same-cycle pop frees a slot and may retire the last entry, so both the
  // full test and the "still busy" test look at occupancy after the pop.
  assign w_pop   = i_rsp_done & (r_count != {CNT_W{1'b0}});
  assign w_full  = (r_count == CNT_W'(MAX_OUTSTANDING)) & ~i_rsp_done;
  assign w_busy  = (r_count != {CNT_W{1'b0}}) & ~((r_count == CNT_W'(1)) & i_rsp_done);
  assign w_stall = w_full | (w_busy & ((w_tgt != r_last_tgt) | (w_miss != r_last_err)));

  // Request steering: forward valid to the target and return its ready.
  always_comb begin
    o_s_valid = {NUM_SLAVES{1'b0}};
    w_ready   = 1'b0;
    if (reset) begin
      o_s_valid = {NUM_SLAVES{1'b0}};
      w_ready   = 1'b0;
    end else if (w_stall) begin
      o_s_valid = {NUM_SLAVES{1'b0}};
      w_ready   = 1'b0;
    end else begin
`ifdef ROUTER_DECERR_EN
      if (w_miss) begin
        w_ready = 1'b1;
      end else begin
        o_s_valid[w_tgt] = m_if.valid;
        w_ready          = i_s_ready[w_tgt];
      end
`else
      o_s_valid[w_tgt] = m_if.valid;
      w_ready          = i_s_ready[w_tgt];
`endif
    end
  end

  assign m_if.ready = w_ready;
  assign w_push     = m_if.valid & w_ready;

`ifdef ROUTER_DECERR_EN
  logic r_mem_err [MAX_OUTSTANDING];

  assign w_push_sel = w_miss ? {SEL_W{1'b0}} : w_tgt;

  // Error flag storage alongside the select entries.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_err[r_wptr] <= w_miss;
    end
  end

  assign o_sel_err = (r_count != {CNT_W{1'b0}}) ? r_mem_err[r_rptr] : 1'b0;
`else
  assign w_push_sel = w_tgt;
  assign o_sel_err  = 1'b0;
`endif

  // Select FIFO storage; contents are only observed while occupied.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_sel[r_wptr] <= w_push_sel;
    end
  end

  // FIFO pointers, occupancy and last-accepted target tracking.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr     <= {PTR_W{1'b0}};
      r_rptr     <= {PTR_W{1'b0}};
      r_count    <= {CNT_W{1'b0}};
      r_last_tgt <= {SEL_W{1'b0}};
      r_last_err <= 1'b0;
    end else begin
      if (w_push) begin
        r_wptr     <= r_wptr + PTR_W'(1);
        r_last_tgt <= w_tgt;
        r_last_err <= w_miss;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_sel_valid   = (r_count != {CNT_W{1'b0}});
  assign o_sel_q       = o_sel_valid ? r_mem_sel[r_rptr] : {SEL_W{1'b0}};
  assign o_outstanding = r_count;

endmodule

// File: doc/axi_addr_router_n.md
Name: axi_addr_router_n

Overview:
- Parametrised AXI address-channel router: one master AR or AW channel fanned out to NUM_SLAVES slaves via a parameter-driven address map.
- Records the target of each accepted transaction in an in-order select FIFO. The data/response mux pops this FIFO to steer returning beats.
- Blocks slave switching while transactions are outstanding to a different slave, so ordering is preserved without IDs.
- Sits between the master interface and the per-slave ports of the interconnect, one instance per address channel.

Parameters:
- NUM_SLAVES, 5: number of slave ports, 2..8.
- SEL_W, 3: select index width; must satisfy 2^SEL_W > NUM_SLAVES.
- SLAVE_BASE, {16'h0004,16'h0003,16'h0002,16'h0001,16'h0000}: packed NUM_SLAVES*16; slave i compares against bits [16i+15:16i].
- SLAVE_MASK, {5{16'hFFFF}}: packed NUM_SLAVES*16; slave i matches when (m_addr[31:16] & mask_i) == (base_i & mask_i).
- DEFAULT_SLAVE, 0: target for unmapped addresses when ROUTER_DECERR_EN is undefined.
- MAX_OUTSTANDING, 4: select FIFO depth, a power of 2, at least 2.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- m_addr  in  32  master address
- m_len  in  8  burst length
- m_size  in  3  beat size
- m_burst  in  2  burst type
- m_valid  in  1  master request valid
- m_ready  out  1  master request accepted
- s_addr  out  NUM_SLAVES*32  broadcast m_addr
- s_len  out  NUM_SLAVES*8  broadcast m_len
- s_size  out  NUM_SLAVES*3  broadcast m_size
- s_burst  out  NUM_SLAVES*2  broadcast m_burst
- s_valid  out  NUM_SLAVES  one-hot-or-zero per-slave valid
- s_ready  in  NUM_SLAVES  per-slave ready
- sel_q  out  SEL_W  FIFO head: slave index of the oldest outstanding transaction
- sel_err  out  1  FIFO head is a decode-error entry
- sel_valid  out  1  FIFO non-empty
- rsp_done  in  1  pulse from the response mux: head transaction complete, pop
- outstanding  out  $clog2(MAX_OUTSTANDING)+1  current FIFO occupancy

Behaviour:
- Decode is combinational. Lowest matching index wins. No match gives miss=1 and tgt=DEFAULT_SLAVE.
- Stall condition: fifo_full, OR (outstanding != 0 AND (tgt != last_tgt OR miss != last_err)).
- last_tgt and last_err are registered on every accept.
- When not stalled:
  - s_valid[tgt] = m_valid; all other s_valid bits are 0.
  - m_ready = s_ready[tgt].
- When stalled: s_valid is all 0 and m_ready = 0.
- Accept = m_valid & m_ready. Accept pushes {miss, tgt} into the FIFO with zero added latency. The entry is visible on sel_q the next cycle if the FIFO was empty.
- Pop on rsp_done & sel_valid. rsp_done while empty is ignored; no underflow, no state change.
- Simultaneous push and pop:
  - Occupancy is unchanged.
  - This is legal when full, because the pop frees a slot in the same cycle, so the full term is computed as (count==MAX_OUTSTANDING) & ~rsp_done.
- Pointers wrap modulo MAX_OUTSTANDING.
- Reset values:
  - FIFO empty; sel_valid=0, sel_q=0, sel_err=0, outstanding=0.
  - last_tgt=0, last_err=0.
  - s_valid=0 and m_ready=0 during the reset cycle.
- Reset mid-burst discards all outstanding entries; no completion is required afterwards.
- Payload broadcast is purely combinational to all slaves.

Optional Feature:
- Macro: ROUTER_DECERR_EN.
- Defined:
  - A miss is never forwarded; all s_valid bits stay 0.
  - An internal error sink accepts the request: m_ready=1 unless stalled.
  - It pushes an entry with sel_err=1 and sel_q=0. The response mux returns DECERR for that entry.
- Undefined:
  - A miss routes to DEFAULT_SLAVE as a normal transaction.
  - sel_err is tied to 0.

Test Plan:
- Single transaction: m_addr=0x0002_0010, m_valid=1, s_ready[2]=1 -> s_valid=5'b00100, m_ready=1; next cycle sel_q=2, sel_valid=1, outstanding=1. Then rsp_done pulse -> outstanding=0.
- Slave switch stall: accept to slave 1 (0x0001_0000), then request to 0x0003_0000 with no rsp_done -> m_ready=0, s_valid=0. The cycle rsp_done pops the slave-1 entry, s_valid[3]=1 and the request is accepted.
- Full FIFO: 4 accepts to slave 0 with no pops -> outstanding=4; 5th request held with m_ready=0. Same-cycle rsp_done accepts it; outstanding stays 4 and sel_q ordering is preserved.
- Backpressure: target slave s_ready=0 for 3 cycles -> s_valid held, no FIFO push. Push happens only on the cycle s_ready=1.
- Unmapped address 0x00FF_0000:
  - Without ROUTER_DECERR_EN: s_valid[0]=1.
  - With the macro: s_valid=0, m_ready=1, next cycle sel_err=1.
- Reset with 3 outstanding -> next cycle outstanding=0, sel_valid=0. rsp_done while empty has no effect.
